// File: rtl/shift_tx_if.sv
// Handshake and serial-line bundle between a parallel producer and shift_tx.
interface shift_tx_if #(
    parameter int DATA_W = 4
);
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic              msb_first;
    logic              sout;
    logic              busy;
    logic              done;

    modport master (
        output din, din_valid, msb_first,
        input  din_ready, sout, busy, done
    );

    modport slave (
        input  din, din_valid, msb_first,
        output din_ready, sout, busy, done
    );
endinterface

// File: rtl/shift_tx.sv
// Parallel-to-serial frame transmitter: start, data, even parity, stop; each bit held CLKS_PER_BIT clocks.
//   state  | meaning
//   IDLE   | line high, ready for a word
//   START  | start bit (low)
//   DATA   | data bits, LSB or MSB first
//   PARITY | even parity of latched word
//   STOP   | stop bit (high); done pulses after it
module shift_tx #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    shift_tx_if.slave  tx
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     clk_cnt, clk_nxt;
    logic [BW-1:0]     bit_cnt, bit_nxt;
    logic [DATA_W-1:0] sh, sh_nxt;
    logic              msb_r, msb_nxt;
    logic              par_r, par_nxt;
    logic              sout_r, sout_nxt;
    logic              done_r, done_nxt;
    logic              clk_last, bit_last;

    assign clk_last = (clk_cnt == CW'(CLKS_PER_BIT - 1));
    assign bit_last = (bit_cnt == BW'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            sh      <= '0;
            msb_r   <= 1'b0;
            par_r   <= 1'b0;
            sout_r  <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            state   <= state_nxt;
            clk_cnt <= clk_nxt;
            bit_cnt <= bit_nxt;
            sh      <= sh_nxt;
            msb_r   <= msb_nxt;
            par_r   <= par_nxt;
            sout_r  <= sout_nxt;
            done_r  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        clk_nxt   = clk_cnt;
        bit_nxt   = bit_cnt;
        sh_nxt    = sh;
        msb_nxt   = msb_r;
        par_nxt   = par_r;
        done_nxt  = 1'b0;
        sout_nxt  = 1'b1;

        case (state)
            IDLE: begin
                if (tx.din_valid) begin
                    state_nxt = START;
                    clk_nxt   = '0;
                    bit_nxt   = '0;
                    sh_nxt    = tx.din;
                    msb_nxt   = tx.msb_first;
                    par_nxt   = ^tx.din;
                end
            end
            START: begin
                if (clk_last) begin
                    clk_nxt   = '0;
                    state_nxt = DATA;
                end else begin
                    clk_nxt = clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (clk_last) begin
                    clk_nxt = '0;
                    if (bit_last) begin
                        bit_nxt   = '0;
                        state_nxt = PARITY;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                        sh_nxt  = msb_r ? (sh << 1) : (sh >> 1);
                    end
                end else begin
                    clk_nxt = clk_cnt + 1'b1;
                end
            end
            PARITY: begin
                if (clk_last) begin
                    clk_nxt   = '0;
                    state_nxt = STOP;
                end else begin
                    clk_nxt = clk_cnt + 1'b1;
                end
            end
            STOP: begin
                if (clk_last) begin
                    clk_nxt   = '0;
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    clk_nxt = clk_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Line level is computed for the state being entered so sout stays a pure register.
        case (state_nxt)
            START:   sout_nxt = 1'b0;
            DATA:    sout_nxt = msb_nxt ? sh_nxt[DATA_W-1] : sh_nxt[0];
            PARITY:  sout_nxt = par_nxt;
            default: sout_nxt = 1'b1;
        endcase
    end

    assign tx.sout      = sout_r;
    assign tx.done      = done_r;
    assign tx.busy      = (state != IDLE);
    assign tx.din_ready = (state == IDLE);
endmodule

// File: tb/tb_shift_tx.sv
// Scoreboard bench for shift_tx: expected line waveforms queued at acceptance, compared per frame.
module tb_shift_tx;
    localparam int DATA_W    = 4;
    localparam int CPB       = 2;
    localparam int FRAME_CYC = (DATA_W + 3) * CPB;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    shift_tx_if #(.DATA_W(DATA_W)) tx ();

    shift_tx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .tx    (tx)
    );

    int total = 0;
    int bad   = 0;

    logic [FRAME_CYC-1:0] exp_q[$];
    logic [FRAME_CYC-1:0] cur_exp;
    logic [FRAME_CYC-1:0] frame;
    logic in_frame = 1'b0;
    int   ncyc     = 0;
    int   done_cnt = 0;
    int   aborted  = 0;
    int   idle_len = 0;
    int   gap_last = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [FRAME_CYC-1:0] exp_frame(input logic [DATA_W-1:0] w, input logic msb);
        logic [FRAME_CYC-1:0] f;
        logic b;
        f = '0;
        for (int s = 0; s < DATA_W + 3; s++) begin
            if (s == 0)               b = 1'b0;
            else if (s <= DATA_W)     b = msb ? w[DATA_W - s] : w[s - 1];
            else if (s == DATA_W + 1) b = ^w;
            else                      b = 1'b1;
            for (int c = 0; c < CPB; c++) f = {f[FRAME_CYC-2:0], b};
        end
        return f;
    endfunction

    // Monitor: collect each frame's line samples and compare against the queued expectation.
    always @(negedge clk) begin
        if (tx.busy === 1'b1) begin
            if (!in_frame) begin
                in_frame = 1'b1;
                ncyc     = 0;
                frame    = '0;
                gap_last = idle_len;
                check_val("sb_has_entry", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) cur_exp = exp_q.pop_front();
            end
            frame = {frame[FRAME_CYC-2:0], tx.sout};
            ncyc++;
        end else begin
            idle_len++;
            if (in_frame) begin
                in_frame = 1'b0;
                idle_len = 1;
                if (tx.done === 1'b1) begin
                    check_val("frame_bits", frame, cur_exp);
                    check_val("frame_len", ncyc, FRAME_CYC);
                end else begin
                    aborted++;
                end
            end
        end
        if (tx.done === 1'b1) done_cnt++;
    end

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n++;
            if (tx.done === 1'b1) return;
        end
        check_val("done_timeout", 0, 1);
    endtask

    task automatic send(input logic [DATA_W-1:0] w, input logic msb, output int n);
        tx.din       = w;
        tx.msb_first = msb;
        tx.din_valid = 1'b1;
        exp_q.push_back(exp_frame(w, msb));
        @(negedge clk);
        tx.din_valid = 1'b0;
        check_val("accepted_busy", tx.busy, 1);
        check_val("accepted_ready", tx.din_ready, 0);
        check_val("start_bit", tx.sout, 0);
        wait_done(n);
    endtask

    int n;
    int dc;

    initial begin
        reset        = 1'b1;
        tx.din       = '0;
        tx.din_valid = 1'b0;
        tx.msb_first = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("idle_sout", tx.sout, 1);
            check_val("idle_ready", tx.din_ready, 1);
            check_val("idle_busy", tx.busy, 0);
            check_val("idle_done", tx.done, 0);
        end

        send(4'b1011, 1'b0, n);
        check_val("done_latency", n, FRAME_CYC);
        check_val("done_ready", tx.din_ready, 1);
        check_val("done_sout", tx.sout, 1);
        @(negedge clk);
        check_val("done_one_cycle", tx.done, 0);

        send(4'b1000, 1'b1, n);
        @(negedge clk);
        send(4'b0000, 1'b1, n);
        @(negedge clk);

        // Toggle inputs mid-frame; they must not disturb the frame in flight.
        dc = done_cnt;
        tx.din       = 4'b1100;
        tx.msb_first = 1'b0;
        tx.din_valid = 1'b1;
        exp_q.push_back(exp_frame(4'b1100, 1'b0));
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            tx.din_valid = i[0];
            tx.din       = 4'($urandom_range(0, 15));
            tx.msb_first = i[1];
            @(negedge clk);
            check_val("busy_ready_low", tx.din_ready, 0);
        end
        tx.din_valid = 1'b0;
        wait_done(n);
        repeat (3) @(negedge clk);
        check_val("ignore_one_done", done_cnt - dc, 1);

        // Back-to-back with din_valid held high.
        dc = done_cnt;
        tx.din       = 4'hA;
        tx.msb_first = 1'b0;
        tx.din_valid = 1'b1;
        exp_q.push_back(exp_frame(4'hA, 1'b0));
        @(negedge clk);
        tx.din = 4'h5;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx.din_ready === 1'b1) break;
        end
        check_val("b2b_ready", tx.din_ready, 1);
        exp_q.push_back(exp_frame(4'h5, 1'b0));
        @(negedge clk);
        tx.din_valid = 1'b0;
        check_val("b2b_second_start", tx.sout, 0);
        wait_done(n);
        check_val("b2b_gap", gap_last, 1);
        repeat (2) @(negedge clk);
        check_val("b2b_two_done", done_cnt - dc, 2);

        // Reset during data bit 2.
        dc = done_cnt;
        tx.din       = 4'b1011;
        tx.msb_first = 1'b0;
        tx.din_valid = 1'b1;
        exp_q.push_back(exp_frame(4'b1011, 1'b0));
        @(negedge clk);
        tx.din_valid = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("rst_sout", tx.sout, 1);
        check_val("rst_ready", tx.din_ready, 1);
        check_val("rst_busy", tx.busy, 0);
        check_val("rst_done", tx.done, 0);
        repeat (4) @(negedge clk);
        check_val("rst_no_done", done_cnt - dc, 0);
        check_val("rst_aborted", aborted, 1);

        send(4'b0110, 1'b1, n);
        check_val("post_rst_latency", n, FRAME_CYC);
        repeat (3) @(negedge clk);
        check_val("sb_drained", exp_q.size(), 0);
        check_val("total_done", done_cnt, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/shift_tx.md
# shift_tx

Parallel-to-serial frame transmitter: the transmitting end of the serial links that our shift registers load through their serial inputs. It accepts a DATA_W-bit word over a valid/ready handshake and sends it on a single line as a framed stream: start bit, data bits, even parity bit, stop bit. Each bit is held for CLKS_PER_BIT clocks. It sits between a parallel producer and a serial-in shift-register receiver.

## Interface
- DATA_W, default 4: data bits per frame; must be ≥1.
- CLKS_PER_BIT, default 4: clocks each bit is held; must be ≥1.

- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- din  input  DATA_W  word to send; sampled on acceptance.
- din_valid  input  1  producer has a word on din.
- din_ready  output  1  block can accept a word; high only in IDLE.
- msb_first  input  1  bit order; sampled on acceptance. 0 = LSB first, 1 = MSB first.
- sout  output  1  serial line; idles high.
- busy  output  1  a frame is in progress (any state other than IDLE).
- done  output  1  one-cycle pulse when a frame completes.

## Operation
- Reset values: sout=1, din_ready=1, busy=0, done=0, state=IDLE. Bit counter, clock-divider counter and shift register are cleared.
- States: IDLE → START → DATA → PARITY → STOP → IDLE.
- IDLE:
  - sout=1, din_ready=1.
  - On an edge with din_valid=1 (acceptance):
    - latch din into the shift register and latch msb_first;
    - compute parity = XOR of din;
    - go to START.
- START: sout=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: sends DATA_W bits, each for CLKS_PER_BIT cycles.
  - LSB first: shift right, sout = reg[0].
  - MSB first: shift left, sout = reg[DATA_W-1].
  - After the last bit, go to PARITY.
- PARITY: sout = XOR of the latched word (even parity: ones in data+parity is even), held CLKS_PER_BIT cycles, then STOP.
- STOP: sout=1 for CLKS_PER_BIT cycles. On the final cycle's edge, go to IDLE and assert done for exactly that next cycle.
- sout is a registered output with no combinational path from any input.
- din_valid outside IDLE is ignored; din_ready=0 there, so no word is lost or overwritten.
- din and msb_first changes after acceptance have no effect on the frame in flight.
- Counter widths: clog2(CLKS_PER_BIT) and clog2(DATA_W), minimum 1 bit. Counters wrap to 0 at each bit and state boundary.

## Timing
- Acceptance edge E: from cycle E+1, sout=0 (start bit), busy=1, din_ready=0.
- Frame length: (DATA_W+3)*CLKS_PER_BIT cycles, covering cycles E+1 through E+(DATA_W+3)*CLKS_PER_BIT.
- Return to IDLE: in cycle E+(DATA_W+3)*CLKS_PER_BIT+1, done=1, din_ready=1, busy=0, sout=1.
- Back-to-back frames: din_valid held high gives acceptance on the done cycle's edge. The next start bit follows immediately, with one idle-high cycle between frames (the done cycle).
- Reset during a frame: on the reset edge, sout returns to 1 and state to IDLE. The frame is abandoned and done does not pulse. Reset takes priority over acceptance on the same edge.
- CLKS_PER_BIT=1: one bit per cycle, frame = DATA_W+3 cycles.

## Test plan
- Reset then idle: assert reset 2 cycles, din_valid=0 → sout=1, din_ready=1, busy=0, done=0 held for 10 cycles.
- LSB-first frame (DATA_W=4, CLKS_PER_BIT=2): din=4'b1011, msb_first=0 → sout per 2-cycle slot 0,1,1,0,1,1,1. done pulses in cycle 15 after the acceptance edge.
- MSB-first and parity: din=4'b1000, msb_first=1 → slots 0,1,0,0,0,1,1. Then din=4'b0000 → parity slot 0.
- Ignored input while busy: toggle din_valid and din mid-frame → din_ready=0 throughout, the transmitted bits are unchanged, and there is exactly one done.
- Back-to-back: din_valid held high with words 4'hA and 4'h5 → two complete frames with exactly one idle-high cycle between them and two done pulses.
- Reset mid-frame: assert reset during the DATA slot of bit 2 → next cycle sout=1, din_ready=1, no done. A new word is then accepted and sent correctly.
